game_timer_chain: RTL and testbench

- Parametrised cascaded digit counter for the game's on-screen timer/score readout. Generalises the single 0..8 digit counter.
- Provides N digits with per-position modulus, up/down mode, freeze on end-of-game, synchronous clear/load, terminal count and wrap flags.
- Clocked by the 1 Hz game tick. Feeds the seven-segment/VGA digit renderers.

---
 rtl/game_timer_pkg.sv | 17 +
 rtl/game_digit_cell.sv | 29 ++
 rtl/game_timer_chain.sv | 136 +++++++++++++
 tb/tb_game_timer_chain.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/game_timer_pkg.sv
// Shared definitions for the cascaded game timer: FSM encodings and
// default digit geometry (two decimal digits spanning 0..89).
package game_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int DEF_N_DIGITS  = 2;
  localparam int DEF_DIGIT_W   = 4;
  localparam int DEF_DIGIT_MOD = 10;
  localparam int DEF_TOP_MOD   = 9;

endpackage

// File: rtl/game_digit_cell.sv
// One digit position of the timer chain.
// Reports its own terminal flags and computes its next value when enabled.
module game_digit_cell #(
  parameter int DIGIT_W = 4
) (
  input  logic [DIGIT_W-1:0] digit,
  input  logic [DIGIT_W:0]   modulus,
  input  logic               enable,
  input  logic               down,
  output logic               at_max,
  output logic               at_zero,
  output logic [DIGIT_W-1:0] next_digit
);

  logic [DIGIT_W:0] last;

  assign last    = modulus - 1'b1;
  assign at_max  = ({1'b0, digit} == last);
  assign at_zero = (digit == '0);

  always_comb begin
    next_digit = digit;
    if (enable) begin
      if (down) next_digit = at_zero ? last[DIGIT_W-1:0] : digit - 1'b1;
      else      next_digit = at_max ? '0 : digit + 1'b1;
    end
  end

endmodule

// File: rtl/game_timer_chain.sv
// Cascaded N-digit game timer with up/down counting, freeze, clear/load,
// terminal-count flag and a one-tick wrap pulse.
module game_timer_chain
  import game_timer_pkg::*;
#(
  parameter int N_DIGITS  = DEF_N_DIGITS,
  parameter int DIGIT_W   = DEF_DIGIT_W,
  parameter int DIGIT_MOD = DEF_DIGIT_MOD,
  parameter int TOP_MOD   = DEF_TOP_MOD,
  parameter int SATURATE  = 0
) (
  input  logic                          clk_1H,
  input  logic                          reset,
  input  logic                          run,
  input  logic                          endf,
  input  logic                          mode_down,
  input  logic                          clear,
  input  logic                          load,
  input  logic [N_DIGITS*DIGIT_W-1:0]   load_val,
  output logic [N_DIGITS*DIGIT_W-1:0]   digits,
  output logic                          tc,
  output logic                          wrap_pulse,
  output logic [1:0]                    state
);

  localparam int W = N_DIGITS * DIGIT_W;
  localparam logic [DIGIT_W:0] LOW_M = DIGIT_MOD[DIGIT_W:0];
  localparam logic [DIGIT_W:0] TOP_M = TOP_MOD[DIGIT_W:0];

  state_t              state_q, state_d;
  logic [W-1:0]        digits_q, next_digits, load_clamped;
  logic                wrap_q;
  logic [N_DIGITS-1:0] at_max, at_zero, en;
  logic                all_max, all_zero;
  logic                adv, sat_stop, count_en, wrap_now;

  function automatic logic [DIGIT_W:0] mod_of(input int i);
    return (i == N_DIGITS - 1) ? TOP_M : LOW_M;
  endfunction

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_cell
    localparam logic [DIGIT_W:0] CELL_M = (g == N_DIGITS - 1) ? TOP_M : LOW_M;
    game_digit_cell #(.DIGIT_W(DIGIT_W)) u_cell (
      .digit      (digits_q[g*DIGIT_W +: DIGIT_W]),
      .modulus    (CELL_M),
      .enable     (en[g]),
      .down       (mode_down),
      .at_max     (at_max[g]),
      .at_zero    (at_zero[g]),
      .next_digit (next_digits[g*DIGIT_W +: DIGIT_W])
    );
  end

  // Ripple carry/borrow: a digit moves only when every lower digit rolls over.
  always_comb begin
    logic carry;
    carry = count_en;
    en    = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      en[i] = carry;
      carry = carry & (mode_down ? at_zero[i] : at_max[i]);
    end
  end

  assign all_max  = &at_max;
  assign all_zero = &at_zero;

  // Releasing a freeze counts on the release tick, so a HALT costs
  // exactly the frozen ticks.
  always_comb begin
    tc       = mode_down ? all_zero : all_max;
    adv      = ~endf & ((state_q == ST_RUN) | ((state_q == ST_HALT) & run));
    sat_stop = adv & tc & (SATURATE != 0);
    count_en = adv & ~sat_stop;
    wrap_now = count_en & tc;
  end

  always_comb begin
    state_d = state_q;
    if (clear | load) begin
      state_d = run ? ST_RUN : ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (run & ~endf) state_d = ST_RUN;
        ST_RUN: begin
          if (endf)          state_d = ST_HALT;
          else if (sat_stop) state_d = ST_DONE;
          else if (!run)     state_d = ST_IDLE;
        end
        ST_HALT: begin
          if (!endf) state_d = sat_stop ? ST_DONE : (run ? ST_RUN : ST_IDLE);
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_1H or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    logic [DIGIT_W:0] m;
    logic [DIGIT_W:0] lm;
    load_clamped = load_val;
    for (int i = 0; i < N_DIGITS; i++) begin
      m  = mod_of(i);
      lm = m - 1'b1;
      if ({1'b0, load_val[i*DIGIT_W +: DIGIT_W]} >= m)
        load_clamped[i*DIGIT_W +: DIGIT_W] = lm[DIGIT_W-1:0];
    end
  end

  always_ff @(posedge clk_1H or posedge reset) begin
    if (reset) begin
      digits_q <= '0;
      wrap_q   <= 1'b0;
    end else if (clear) begin
      digits_q <= '0;
      wrap_q   <= 1'b0;
    end else if (load) begin
      digits_q <= load_clamped;
      wrap_q   <= 1'b0;
    end else begin
      if (count_en) digits_q <= next_digits;
      wrap_q <= wrap_now;
    end
  end

  assign digits     = digits_q;
  assign wrap_pulse = wrap_q;
  assign state      = state_q;

endmodule

// File: tb/tb_game_timer_chain.sv
// Self-checking bench for game_timer_chain: a wrapping instance and a
// saturating instance share stimulus; expectations come from a decimal model.
module tb_game_timer_chain;

  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_HALT = 2;
  localparam int S_DONE = 3;

  logic       clk_1H = 1'b0;
  logic       reset, run, endf, mode_down, clear, load;
  logic [7:0] load_val;
  logic [7:0] digits, digits_s;
  logic       tc, tc_s, wrap_pulse, wrap_s;
  logic [1:0] state, state_s;

  int n_checks = 0;
  int n_fail   = 0;

  // {sel, digit1, digit0, tc, wrap, state}; sel = 1 targets the saturating instance
  logic [12:0] exp_q[$];
  string       name_q[$];

  typedef struct {
    logic       run;
    logic       endf;
    logic       md;
    logic       clr;
    logic       ld;
    logic [7:0] lv;
    int         val;
    int         st;
    logic       wr;
  } vec_t;

  vec_t vecs[12];

  always #5 clk_1H = ~clk_1H;

  game_timer_chain #(
    .N_DIGITS(2), .DIGIT_W(4), .DIGIT_MOD(10), .TOP_MOD(9), .SATURATE(0)
  ) dut (
    .clk_1H(clk_1H), .reset(reset), .run(run), .endf(endf),
    .mode_down(mode_down), .clear(clear), .load(load), .load_val(load_val),
    .digits(digits), .tc(tc), .wrap_pulse(wrap_pulse), .state(state)
  );

  game_timer_chain #(
    .N_DIGITS(2), .DIGIT_W(4), .DIGIT_MOD(10), .TOP_MOD(9), .SATURATE(1)
  ) dut_sat (
    .clk_1H(clk_1H), .reset(reset), .run(run), .endf(endf),
    .mode_down(mode_down), .clear(clear), .load(load), .load_val(load_val),
    .digits(digits_s), .tc(tc_s), .wrap_pulse(wrap_s), .state(state_s)
  );

  function automatic logic [12:0] pack_exp(input logic sel, input int val,
                                           input int st, input logic wr,
                                           input logic md);
    logic [3:0] hi, lo;
    logic       t;
    hi = 4'(val / 10);
    lo = 4'(val % 10);
    t  = md ? (val == 0) : (val == 89);
    return {sel, hi, lo, t, wr, 2'(st)};
  endfunction

  task automatic drive(input logic r, input logic e, input logic md,
                       input logic c, input logic l, input logic [7:0] lv);
    run = r; endf = e; mode_down = md; clear = c; load = l; load_val = lv;
  endtask

  task automatic compare(input logic [12:0] e, input string nm);
    logic [11:0] act;
    if (e[12]) act = {digits_s, tc_s, wrap_s, state_s};
    else       act = {digits, tc, wrap_pulse, state};
    n_checks++;
    if (act !== e[11:0]) begin
      n_fail++;
      $display("FAIL %s: got digits=%h tc=%b wrap=%b state=%0d, expected digits=%h tc=%b wrap=%b state=%0d",
               nm, act[11:4], act[3], act[2], act[1:0], e[11:4], e[3], e[2], e[1:0]);
    end
  endtask

  task automatic step(input logic [12:0] e, input string nm);
    logic [12:0] ex;
    string       en;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk_1H);
    #1;
    ex = exp_q.pop_front();
    en = name_q.pop_front();
    compare(ex, en);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 10, S_RUN,  1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00,  9, S_RUN,  1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00,  0, S_RUN,  1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 89, S_RUN,  1'b1};
    vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 88, S_RUN,  1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 89, S_RUN,  1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 88, S_RUN,  1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 89, S_IDLE, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 89, S_IDLE, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF,  0, S_IDLE, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h95, 85, S_IDLE, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h0A,  9, S_IDLE, 1'b0};

    // Reset state
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    #2;
    compare(pack_exp(1'b0, 0, S_IDLE, 1'b0, 1'b0), "reset_state");
    compare(pack_exp(1'b1, 0, S_IDLE, 1'b0, 1'b0), "reset_state_sat");
    @(posedge clk_1H);
    #1;
    reset = 1'b0;

    // Full up-count cycle with wrap
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(pack_exp(1'b0, 0, S_RUN, 1'b0, 1'b0), "idle_to_run");
    for (int k = 1; k <= 90; k++)
      step(pack_exp(1'b0, k % 90, S_RUN, k == 90, 1'b0), $sformatf("count_up_%0d", k));
    step(pack_exp(1'b0, 1, S_RUN, 1'b0, 1'b0), "wrap_pulse_clears");

    // Down count, clear, down wrap, mode switch, load clamp, clear over load
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].run, vecs[i].endf, vecs[i].md, vecs[i].clr, vecs[i].ld, vecs[i].lv);
      step(pack_exp(1'b0, vecs[i].val, vecs[i].st, vecs[i].wr, vecs[i].md),
           $sformatf("vec_%0d", i));
    end

    // Freeze at 23
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h23);
    step(pack_exp(1'b0, 23, S_RUN, 1'b0, 1'b0), "load_23");
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int k = 0; k < 5; k++)
      step(pack_exp(1'b0, 23, S_HALT, 1'b0, 1'b0), $sformatf("halt_%0d", k));
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(pack_exp(1'b0, 24, S_RUN, 1'b0, 1'b0), "resume_24");
    step(pack_exp(1'b0, 25, S_RUN, 1'b0, 1'b0), "resume_25");

    // Saturating instance
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h88);
    step(pack_exp(1'b1, 88, S_RUN, 1'b0, 1'b0), "sat_load_88");
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(pack_exp(1'b1, 89, S_RUN, 1'b0, 1'b0), "sat_reach_89");
    step(pack_exp(1'b1, 89, S_DONE, 1'b0, 1'b0), "sat_done");
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(pack_exp(1'b1, 89, S_DONE, 1'b0, 1'b0), "sat_done_run0");
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(pack_exp(1'b1, 89, S_DONE, 1'b0, 1'b0), "sat_done_run1");
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    step(pack_exp(1'b1, 89, S_DONE, 1'b0, 1'b0), "sat_done_endf");
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    step(pack_exp(1'b1, 0, S_RUN, 1'b0, 1'b0), "sat_clear");
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(pack_exp(1'b1, 1, S_RUN, 1'b0, 1'b0), "sat_count_on");

    // Asynchronous reset mid-count at 47
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h46);
    step(pack_exp(1'b0, 46, S_RUN, 1'b0, 1'b0), "load_46");
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(pack_exp(1'b0, 47, S_RUN, 1'b0, 1'b0), "count_47");
    #2;
    reset = 1'b1;
    #1;
    compare(pack_exp(1'b0, 0, S_IDLE, 1'b0, 1'b0), "async_reset");
    compare(pack_exp(1'b1, 0, S_IDLE, 1'b0, 1'b0), "async_reset_sat");
    @(posedge clk_1H);
    #1;
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
